// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake direction path.
package snake_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_R = 2'b00;
   localparam dir_t DIR_U = 2'b01;
   localparam dir_t DIR_D = 2'b10;
   localparam dir_t DIR_L = 2'b11;

   // The encoding puts opposite headings at bitwise complements (R/L, U/D).
   function automatic logic is_opposite(input dir_t a, input dir_t b);
      return &(a ^ b);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, level debouncer and rising-edge pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          stable;
   logic          stable_d;
   logic [CW-1:0] cnt;

   // Synchronise, then accept a new level only after it has differed from the
   // stable level for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         sync_q   <= '0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= '0;
      end else begin
         sync_q   <= {sync_q[0], raw};
         stable_d <= stable;
         if (sync_q[1] == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync_q[1];
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // One-cycle pulse on accepted rising levels only; releases are ignored.
   assign press = stable & ~stable_d;

endmodule

// File: rtl/dir_input_queue.sv
// Snake direction front end: four debounced buttons feed a filtered circular
// FIFO that the game engine drains one heading per movement tick.
module dir_input_queue
   import snake_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter int   QUEUE_DEPTH     = 2,
   parameter dir_t RESET_DIR       = DIR_R
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             btn_up,
   input  logic                             btn_down,
   input  logic                             btn_left,
   input  logic                             btn_right,
   input  logic                             tick,
   input  logic                             flush,
   output dir_t                             dir,
   output logic                             dir_chg,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0] q_count,
   output logic                             overflow
);

   localparam int CNTW = $clog2(QUEUE_DEPTH + 1);
   localparam int PW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(QUEUE_DEPTH);
   localparam logic [PW-1:0]   PTR_LAST = PW'(QUEUE_DEPTH - 1);

   logic          press_up, press_down, press_left, press_right;
   logic          cand_valid;
   dir_t          cand;
   dir_t          tail;
   logic [PW-1:0] newest;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          accept, do_push, do_pop, drop;
   dir_t          mem [QUEUE_DEPTH];

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up    (.clk(clk), .reset(reset), .raw(btn_up),    .press(press_up));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down  (.clk(clk), .reset(reset), .raw(btn_down),  .press(press_down));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left  (.clk(clk), .reset(reset), .raw(btn_left),  .press(press_left));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (.clk(clk), .reset(reset), .raw(btn_right), .press(press_right));

   // Same-cycle presses resolve up > down > left > right; the rest are lost.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      cand_valid = 1'b1;
      cand       = DIR_R;
      if (press_up)         cand = DIR_U;
      else if (press_down)  cand = DIR_D;
      else if (press_left)  cand = DIR_L;
      else if (press_right) cand = DIR_R;
      else                  cand_valid = 1'b0;
   end

   // Filter against the newest queued heading (or the live heading when the
   // queue is empty), taken before this cycle's pop; flush wins over all.
   always_comb begin
      newest  = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PW'(1);
      tail    = (q_count != '0) ? mem[newest] : dir;
      accept  = cand_valid && (cand != tail) && !is_opposite(cand, tail);
      do_pop  = !flush && tick && (q_count != '0);
      do_push = !flush && accept && ((q_count != DEPTH_C) || do_pop);
      drop    = !flush && accept && (q_count == DEPTH_C) && !do_pop;
   end

   // Queue storage holds data only; occupancy lives in q_count.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; q_count==0 after
      // reset makes its contents unobservable, and it maps cleanly to RAM.
      if (do_push) mem[wr_ptr] <= cand;
   end

   // Pointers, occupancy, heading and the one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         q_count  <= '0;
         dir      <= RESET_DIR;
         dir_chg  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         dir_chg  <= do_pop;
         overflow <= drop;
         if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
         end else begin
            if (do_pop) begin
               dir    <= mem[rd_ptr];
               rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_push && !do_pop)      q_count <= q_count + CNTW'(1);
            else if (do_pop && !do_push) q_count <= q_count - CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_dir_input_queue.sv
// Directed bench for dir_input_queue (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2).
module tb_dir_input_queue;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn;         // [0]=up [1]=down [2]=left [3]=right
   logic       tick;
   logic       flush;
   logic [1:0] dir;
   logic       dir_chg;
   logic [1:0] q_count;
   logic       overflow;

   int n_vec = 0;
   int n_bad = 0;
   int ovf_seen = 0;
   int ovf_base;

   dir_input_queue #(
      .DEBOUNCE_CYCLES(4),
      .QUEUE_DEPTH(2),
      .RESET_DIR(2'b00)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_up(btn[0]),
      .btn_down(btn[1]),
      .btn_left(btn[2]),
      .btn_right(btn[3]),
      .tick(tick),
      .flush(flush),
      .dir(dir),
      .dir_chg(dir_chg),
      .q_count(q_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Count overflow pulses on the falling edge so silent pulses are caught.
   always @(negedge clk) if (overflow) ovf_seen++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Hold one button for 7 edges: its press reaches the queue on edge 7.
   task automatic hold(input int idx);
      btn[idx] = 1'b1;
      repeat (7) step();
   endtask

   // Release everything and let the debouncers settle back to idle.
   task automatic settle();
      btn = '0;
      repeat (10) step();
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      btn   = '0;
      tick  = 1'b0;
      flush = 1'b0;
      repeat (3) step();

      // 1: reset state, tick on empty queue
      do_reset();
      check("rst_dir", dir, 2'b00);
      check("rst_qcnt", q_count, 0);
      check("rst_dirchg", dir_chg, 0);
      check("rst_ovf", overflow, 0);
      pulse_tick();
      check("empty_tick_dir", dir, 2'b00);
      check("empty_tick_chg", dir_chg, 0);

      // 2: held up, latency and pop
      btn[0] = 1'b1;
      repeat (6) step();
      check("lat_edge6_q", q_count, 0);
      step();
      check("lat_edge7_q", q_count, 1);
      repeat (5) step();
      settle();
      check("up_still_q1", q_count, 1);
      check("up_dir_before_tick", dir, 2'b00);
      pulse_tick();
      check("pop_dir", dir, 2'b01);
      check("pop_chg", dir_chg, 1);
      check("pop_q", q_count, 0);
      step();
      check("pop_chg_drop", dir_chg, 0);

      // 3: bouncing up button never accepted
      do_reset();
      for (int i = 0; i < 30; i++) begin
         btn[0] = ((i / 2) % 2) == 0;
         step();
      end
      settle();
      check("bounce_q", q_count, 0);

      // 4: reversal, duplicate, then up accepted and down rejected vs tail
      do_reset();
      ovf_base = ovf_seen;
      hold(2); settle();
      check("left_reversal_q", q_count, 0);
      hold(3); settle();
      check("right_dup_q", q_count, 0);
      hold(0); settle();
      check("up_queued_q", q_count, 1);
      hold(1); settle();
      check("down_vs_tail_q", q_count, 1);
      check("filter_no_ovf", ovf_seen - ovf_base, 0);
      check("filter_dir", dir, 2'b00);

      // 5: fill, overflow on third, drain in order
      do_reset();
      hold(0); settle();
      hold(2); settle();
      check("fill_q", q_count, 2);
      ovf_base = ovf_seen;
      hold(1);
      check("ovf_pulse", overflow, 1);
      check("ovf_q", q_count, 2);
      step();
      check("ovf_pulse_end", overflow, 0);
      settle();
      check("ovf_count", ovf_seen - ovf_base, 1);
      pulse_tick();
      check("drain1_dir", dir, 2'b01);
      pulse_tick();
      check("drain2_dir", dir, 2'b11);
      check("drain_q", q_count, 0);

      // 6: full + tick + accepted press; then flush with tick
      do_reset();
      hold(0); settle();
      hold(2); settle();
      ovf_base = ovf_seen;
      btn[0] = 1'b1;
      repeat (6) step();
      pulse_tick();
      check("pushpop_q", q_count, 2);
      check("pushpop_dir", dir, 2'b01);
      check("pushpop_chg", dir_chg, 1);
      settle();
      check("pushpop_no_ovf", ovf_seen - ovf_base, 0);
      flush = 1'b1;
      tick  = 1'b1;
      step();
      flush = 1'b0;
      tick  = 1'b0;
      check("flush_q", q_count, 0);
      check("flush_dir", dir, 2'b01);
      check("flush_chg", dir_chg, 0);
      pulse_tick();
      check("post_flush_tick_dir", dir, 2'b01);

      // 7: reset mid-debounce, button still held counts as a fresh press
      do_reset();
      btn[0] = 1'b1;
      repeat (4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_q", q_count, 0);
      repeat (6) step();
      check("midrst_edge6_q", q_count, 0);
      step();
      check("midrst_edge7_q", q_count, 1);
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
